// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the instruction encoder: format enum, opcodes,
// per-format immediate limits and the immediate range-check helper.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6f;

  localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_I_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_S_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_S_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX =  32'sd1048574;

  // B and J offsets must also be even; U needs its low 12 bits clear.
  function automatic logic imm_in_range(input fmt_e fmt, input logic [31:0] imm);
    logic signed [31:0] simm;
    logic               ok;
    simm = signed'(imm);
    case (fmt)
      FMT_R:   ok = 1'b1;
      FMT_I:   ok = (simm >= IMM_I_MIN) && (simm <= IMM_I_MAX);
      FMT_S:   ok = (simm >= IMM_S_MIN) && (simm <= IMM_S_MAX);
      FMT_B:   ok = (simm >= IMM_B_MIN) && (simm <= IMM_B_MAX) && (imm[0] == 1'b0);
      FMT_U:   ok = (imm[11:0] == 12'd0);
      FMT_J:   ok = (simm >= IMM_J_MIN) && (simm <= IMM_J_MAX) && (imm[0] == 1'b0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packing for all six formats plus legality flag.
// With IMM_RANGE_CHECK_EN defined, out-of-range immediates are flagged illegal.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        legal
);

  fmt_e fmt_s;
  logic fmt_ok_s;
  logic range_ok_s;

  assign fmt_s = fmt_e'(fmt);

`ifdef IMM_RANGE_CHECK_EN
  assign range_ok_s = imm_in_range(fmt_s, imm);
`else
  assign range_ok_s = 1'b1;
`endif

  assign legal = fmt_ok_s && range_ok_s;

  // Format-dependent bit scatter; unused fields simply do not appear.
  always_comb begin
    instr    = 32'd0;
    fmt_ok_s = 1'b1;
    case (fmt_s)
      FMT_R:   instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   instr = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   instr = {imm[31:12], rd, opcode};
      FMT_J:   instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: fmt_ok_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: packer, 2-entry in-order output FIFO, emit counter, err pulse.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt
);

  logic [31:0]      word_s;
  logic             legal_s;
  logic             accept_s;
  logic             emit_s;
  logic             push_s;
  logic [1:0]       occ_r;
  logic [31:0]      slot0_r;
  logic [31:0]      slot1_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (word_s),
    .legal  (legal_s)
  );

  assign in_ready  = (occ_r < 2'd2);
  assign out_valid = (occ_r != 2'd0);
  assign out_instr = slot0_r;
  assign err       = err_r;
  assign instr_cnt = cnt_r;

  assign accept_s = in_valid && in_ready;
  assign emit_s   = out_valid && out_ready;
  assign push_s   = accept_s && legal_s;

  // slot0 is always the head; push+emit only occurs at occupancy 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_r   <= 2'd0;
      slot0_r <= 32'd0;
      slot1_r <= 32'd0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      err_r <= accept_s && !legal_s;
      if (emit_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      case ({push_s, emit_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            slot0_r <= word_s;
          end else begin
            slot1_r <= word_s;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          occ_r   <= occ_r - 2'd1;
        end
        2'b11:   slot0_r <= word_s;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        err;
  logic [15:0] instr_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] q[$];
  int          exp_cnt = 0;
  bit          exp_err = 1'b0;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .err(err), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int v, input int hi, input int lo);
    logic [31:0] u;
    u = v;
    return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Encoding built from the format rules with shifts and masks.
  task automatic ref_encode(output logic [31:0] w, output bit lg);
    logic [31:0] op, rd, r1, r2, f3, f7;
    int imm;
    op = in_opcode; rd = in_rd; r1 = in_rs1; r2 = in_rs2; f3 = in_funct3; f7 = in_funct7;
    imm = int'(in_imm);
    lg = 1'b1;
    w = 32'd0;
    case (int'(in_fmt))
      0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        w = (fld(imm, 11, 0) << 20) | (r1 << 15) | (f3 << 12) | (rd << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
        lg = (imm >= -2048) && (imm <= 2047);
`endif
      end
      2: begin
        w = (fld(imm, 11, 5) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (fld(imm, 4, 0) << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
        lg = (imm >= -2048) && (imm <= 2047);
`endif
      end
      3: begin
        w = (fld(imm, 12, 12) << 31) | (fld(imm, 10, 5) << 25) | (r2 << 20) | (r1 << 15) |
            (f3 << 12) | (fld(imm, 4, 1) << 8) | (fld(imm, 11, 11) << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
        lg = (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
`endif
      end
      4: begin
        w = (fld(imm, 31, 12) << 12) | (rd << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
        lg = ((imm & 32'hfff) == 0);
`endif
      end
      5: begin
        w = (fld(imm, 20, 20) << 31) | (fld(imm, 10, 1) << 21) | (fld(imm, 11, 11) << 20) |
            (fld(imm, 19, 12) << 12) | (rd << 7) | op;
`ifdef IMM_RANGE_CHECK_EN
        lg = (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
`endif
      end
      default: lg = 1'b0;
    endcase
  endtask

  // One clock: model update at the edge, DUT comparison on the following falling edge.
  task automatic cycle();
    bit acc, emt, lg;
    logic [31:0] w;
    acc = in_valid && (q.size() < 2);
    emt = (q.size() > 0) && out_ready;
    ref_encode(w, lg);
    @(posedge clk);
    if (emt) begin
      void'(q.pop_front());
      exp_cnt = (exp_cnt + 1) % 65536;
    end
    if (acc && lg) q.push_back(w);
    exp_err = acc && !lg;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("err", {31'd0, err}, {31'd0, exp_err});
    check("instr_cnt", {16'd0, instr_cnt}, exp_cnt);
    if (q.size() > 0) check("out_instr", out_instr, q[0]);
  endtask

  task automatic rand_req();
    int sel;
    in_valid  = ($urandom_range(0, 3) != 0);
    in_fmt    = 3'($urandom_range(0, 7));
    in_opcode = 7'($urandom);
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    sel = $urandom_range(0, 3);
    case (sel)
      0: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: in_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
      2: in_imm = $urandom & 32'hffff_f000;
      default: in_imm = $urandom;
    endcase
    out_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [31:0] imm);
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
    in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = imm;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_cnt", {16'd0, instr_cnt}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    q.delete();
    exp_cnt = 0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] w1, w2;
    bit lg;

    do_reset();

    // Directed I-format example.
    set_req(3'd1, OPC_OP_IMM, 5'd1, 5'd2, 5'd0, 32'hffff_ffff);
    out_ready = 1'b1;
    cycle();
    check("req032_word", out_instr, 32'hfff10093);
    in_valid = 1'b0;
    cycle();
    check("req032_cnt", {16'd0, instr_cnt}, 32'd1);

    // Directed B-format, even then odd offset.
    set_req(3'd3, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 32'd8);
    cycle();
    check("req033_word", out_instr, 32'h00208463);
    in_imm = 32'd7;
    cycle();
`ifdef IMM_RANGE_CHECK_EN
    check("req033_odd_err", {31'd0, err}, 32'd1);
    check("req033_odd_nout", {31'd0, out_valid}, 32'd0);
`else
    check("req033_odd_trunc", out_instr, 32'h00208363);
`endif
    in_valid = 1'b0;
    repeat (3) cycle();

    // Backpressure: two accepted, third refused, then ordered drain.
    out_ready = 1'b0;
    set_req(3'd0, OPC_OP, 5'd3, 5'd4, 5'd5, 32'd0);
    ref_encode(w1, lg);
    cycle();
    in_rd = 5'd6;
    ref_encode(w2, lg);
    cycle();
    check("req034_full", {31'd0, in_ready}, 32'd0);
    in_rd = 5'd9;
    cycle();
    in_valid = 1'b0;
    check("req034_head1", out_instr, w1);
    out_ready = 1'b1;
    cycle();
    check("req034_head2", out_instr, w2);
    cycle();
    check("req034_empty", {31'd0, out_valid}, 32'd0);

    // Illegal format pulse.
    set_req(3'd7, OPC_OP, 5'd1, 5'd1, 5'd1, 32'd0);
    cycle();
    check("req035_err", {31'd0, err}, 32'd1);
    check("req035_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    cycle();
    check("req035_err_off", {31'd0, err}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      rand_req();
      cycle();
    end

    // Reset with two words buffered; nothing stale afterwards.
    out_ready = 1'b0;
    set_req(3'd0, OPC_OP, 5'd1, 5'd2, 5'd3, 32'd0);
    repeat (3) cycle();
    do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) cycle();
    check("req037_no_stale", {31'd0, out_valid}, 32'd0);

    // Counter wrap: one word per cycle until the count reaches 0xFFFF.
    set_req(3'd0, OPC_OP, 5'd1, 5'd2, 5'd3, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 70000 && exp_cnt != 65535; i++) begin
      in_rd = 5'($urandom);
      cycle();
    end
    check("req036_ffff", {16'd0, instr_cnt}, 32'h0000ffff);
    cycle();
    check("req036_wrap0", {16'd0, instr_cnt}, 32'h00000000);
    cycle();
    check("req036_wrap1", {16'd0, instr_cnt}, 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
